// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM with redirect and drop handling
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misalign_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;
  logic [1:0]  state;
  logic [31:0] pc, drop_addr, instr_q, rpc;
  logic        rst_seen;
  assign rpc         = {redirect_pc[31:2], 2'b00};
  assign imem_req    = (state == FETCH) || (state == DROP);
  // DROP keeps presenting the abandoned address until its ack drains
  assign imem_addr   = (state == DROP) ? drop_addr : pc;
  assign instr_valid = (state == HOLD);
  assign instr       = instr_valid ? instr_q : NOP_INSTR;
  // rst_seen holds IDLE for one edge so the first request rises on the 2nd edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      drop_addr    <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instr_pc     <= 32'h0;
      misalign_err <= 1'b0;
      rst_seen     <= 1'b0;
    end else begin
      rst_seen     <= 1'b1;
      misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        pc <= rpc;
        if (state == FETCH && !imem_ack) begin
          drop_addr <= pc;
          state     <= DROP;
        end else if (state != DROP) begin
          state <= FETCH;
        end
      end else begin
        case (state)
          IDLE:  if (rst_seen) state <= FETCH;
          FETCH: if (imem_ack) begin
            instr_q  <= imem_rdata;
            instr_pc <= pc;
            pc       <= pc + 32'd4;
            state    <= HOLD;
          end
          HOLD:  if (instr_ready) state <= FETCH;
          DROP:  if (imem_ack) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenario tests for instr_fetch
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst_n = 1'b1, imem_ack = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0, redirect_pc = 32'h0;
  logic        imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr, instr_pc;
  int passed = 0, total = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else passed++;
    total++; if (instr !== NOP) $display("FAIL rst_instr: got %h want %h", instr, NOP); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h want 0", instr_pc); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL rst_misalign: got %0b want 0", misalign_err); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (imem_req !== 1'b0) $display("FAIL first_edge_req: got %0b want 0", imem_req); else passed++;
    step();
    total++; if (imem_req !== 1'b1) $display("FAIL second_edge_req: got %0b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL second_edge_addr: got %h want 0", imem_addr); else passed++;
  endtask

  task automatic test_sequential();
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (imem_req !== 1'b1) $display("FAIL seq_req[%0d]: got %0b want 1", k, imem_req); else passed++;
      total++; if (imem_addr !== 32'(4 * k)) $display("FAIL seq_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * k)); else passed++;
      total++; if (instr_valid !== 1'b0) $display("FAIL seq_pre_valid[%0d]: got %0b want 0", k, instr_valid); else passed++;
      imem_ack = 1'b1;
      imem_rdata = 32'hA000_0000 + 32'(k);
      step();
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %0b want 1", k, instr_valid); else passed++;
      total++; if (instr !== 32'hA000_0000 + 32'(k)) $display("FAIL seq_instr[%0d]: got %h want %h", k, instr, 32'hA000_0000 + 32'(k)); else passed++;
      total++; if (instr_pc !== 32'(4 * k)) $display("FAIL seq_instr_pc[%0d]: got %h want %h", k, instr_pc, 32'(4 * k)); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL seq_hold_req[%0d]: got %0b want 0", k, imem_req); else passed++;
      step();
    end
    total++; if (imem_addr !== 32'h10) $display("FAIL seq_next_addr: got %h want 10", imem_addr); else passed++;
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_00B0;
    step();
    imem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++; if (instr_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %0b want 1", k, instr_valid); else passed++;
      total++; if (instr !== 32'hB0) $display("FAIL bp_instr[%0d]: got %h want b0", k, instr); else passed++;
      total++; if (instr_pc !== 32'h10) $display("FAIL bp_instr_pc[%0d]: got %h want 10", k, instr_pc); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL bp_req[%0d]: got %0b want 0", k, imem_req); else passed++;
      step();
    end
    instr_ready = 1'b1;
    step();
    total++; if (imem_req !== 1'b1) $display("FAIL bp_resume_req: got %0b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h14) $display("FAIL bp_resume_addr: got %h want 14", imem_addr); else passed++;
  endtask

  task automatic test_redirect_inflight();
    instr_ready = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_00C0;
    step();
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h8;
    instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL hold_redir_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (imem_addr !== 32'h8) $display("FAIL hold_redir_addr: got %h want 8", imem_addr); else passed++;
    step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    total++; if (imem_req !== 1'b1) $display("FAIL drop_req: got %0b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h8) $display("FAIL drop_addr: got %h want 8", imem_addr); else passed++;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_0008;
    step();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL drop_data_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (instr !== NOP) $display("FAIL drop_instr: got %h want %h", instr, NOP); else passed++;
    total++; if (imem_addr !== 32'h100) $display("FAIL drop_next_addr: got %h want 100", imem_addr); else passed++;
    step();
    total++; if (instr_valid !== 1'b0) $display("FAIL drop_later_valid: got %0b want 0", instr_valid); else passed++;
  endtask

  task automatic test_redirect_ack();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_0100;
    step();
    redirect = 1'b0;
    imem_ack = 1'b0;
    total++; if (imem_req !== 1'b1) $display("FAIL redir_ack_req: got %0b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h40) $display("FAIL redir_ack_addr: got %h want 40", imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL redir_ack_valid: got %0b want 0", instr_valid); else passed++;
  endtask

  task automatic test_misaligned();
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_040D;
    instr_ready = 1'b0;
    step();
    imem_ack = 1'b0;
    total++; if (instr_pc !== 32'h40) $display("FAIL mis_pre_pc: got %h want 40", instr_pc); else passed++;
    redirect = 1'b1;
    redirect_pc = 32'h103;
    instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    total++; if (misalign_err !== 1'b1) $display("FAIL mis_pulse: got %0b want 1", misalign_err); else passed++;
    total++; if (imem_addr !== 32'h100) $display("FAIL mis_addr: got %h want 100", imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL mis_valid: got %0b want 0", instr_valid); else passed++;
    step();
    total++; if (misalign_err !== 1'b0) $display("FAIL mis_pulse_end: got %0b want 0", misalign_err); else passed++;
  endtask

  task automatic test_drop_redirect();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== 32'h100) $display("FAIL drop2_addr: got %h want 100", imem_addr); else passed++;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 32'h300) $display("FAIL drop2_next_addr: got %h want 300", imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL drop2_valid: got %0b want 0", instr_valid); else passed++;
  endtask

  task automatic test_ack_ignored();
    instr_ready = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_300D;
    step();
    imem_rdata = 32'hBAD0_0300;
    step();
    imem_ack = 1'b0;
    total++; if (instr !== 32'h300D) $display("FAIL hold_ack_instr: got %h want 300d", instr); else passed++;
    total++; if (instr_pc !== 32'h300) $display("FAIL hold_ack_pc: got %h want 300", instr_pc); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL hold_ack_req: got %0b want 0", imem_req); else passed++;
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b1;
    step();
    total++; if (imem_addr !== 32'h304) $display("FAIL mid_pre_addr: got %h want 304", imem_addr); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL mid_rst_req: got %0b want 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL mid_rst_addr: got %h want 0", imem_addr); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL mid_rst_pc: got %h want 0", instr_pc); else passed++;
    total++; if (instr !== NOP) $display("FAIL mid_rst_instr: got %h want %h", instr, NOP); else passed++;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_0304;
    step();
    rst_n = 1'b1;
    step();
    total++; if (instr_valid !== 1'b0) $display("FAIL mid_idle_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL mid_idle_req: got %0b want 0", imem_req); else passed++;
    step();
    imem_ack = 1'b0;
    total++; if (imem_req !== 1'b1) $display("FAIL mid_refetch_req: got %0b want 1", imem_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL mid_refetch_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL mid_refetch_addr: got %h want 0", imem_addr); else passed++;
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_ack = 1'b1;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); else passed++;
    imem_rdata = 32'h0000_00FC;
    instr_ready = 1'b0;
    step();
    imem_ack = 1'b0;
    total++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_instr_pc: got %h want fffffffc", instr_pc); else passed++;
    total++; if (instr !== 32'hFC) $display("FAIL wrap_instr: got %h want fc", instr); else passed++;
    instr_ready = 1'b1;
    step();
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 0", imem_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_ack();
    test_misaligned();
    test_drop_redirect();
    test_ack_ignored();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
